// File: rtl/quad_pkg.sv
// ============================================================================
//  quad_pkg -- shared types and constants for the quadrature decoder
//  Rev 1.0
// ============================================================================
`default_nettype none

package quad_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef logic [1:0] phase_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Position of a {A,B} phase along the forward Gray cycle 00->01->11->10.
    function automatic logic [1:0] phase_pos(input phase_t p);
        logic [1:0] pos;
        case (p)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quad_filter.sv
// ============================================================================
//  quad_filter -- 2-flop synchronizer plus stability filter for one channel
//  Rev 1.0
// ============================================================================
`default_nettype none

module quad_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic filt,
    output logic quiet
);

    logic       r_s1;
    logic       r_s2;
    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            filt  <= 1'b0;
            r_cnt <= 4'd0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            if (r_s2 == filt) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == 4'(FILT_LEN - 1)) begin
                filt  <= r_s2;
                r_cnt <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Nothing in flight anywhere in the synchronizer/filter chain.
    assign quiet = (r_s1 == r_s2) && (r_s2 == filt);

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
//  quad_decoder -- filtered quadrature decoder with inc/dec/err pulses
//  Rev 1.0
// ============================================================================
`default_nettype none

module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       en,
    input  logic       clr_err,
    output logic       inc,
    output logic       dec,
    output logic       err,
    output logic [7:0] err_cnt
);

    logic       w_a_f;
    logic       w_b_f;
    logic       w_a_quiet;
    logic       w_b_quiet;
    phase_t     w_ab;
    logic [1:0] w_dist;
    logic       w_fwd;
    logic       w_rev;
    logic       w_bad;

    state_t     r_state;
    phase_t     r_phase;
    logic [3:0] r_init_cnt;

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (a_in),
        .filt  (w_a_f),
        .quiet (w_a_quiet)
    );

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (b_in),
        .filt  (w_b_f),
        .quiet (w_b_quiet)
    );

    assign w_ab   = {w_a_f, w_b_f};
    // Signed step along the Gray cycle: 1 forward, 3 reverse, 2 skipped a phase.
    assign w_dist = phase_pos(w_ab) - phase_pos(r_phase);
    assign w_fwd  = (r_state == TRACK) && (w_dist == 2'd1);
    assign w_rev  = (r_state == TRACK) && (w_dist == 2'd3);
    assign w_bad  = (r_state == TRACK) && (w_dist == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_phase    <= 2'b00;
            r_init_cnt <= 4'd0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            inc <= en & w_fwd;
            dec <= en & w_rev;
            err <= en & w_bad;

            if (clr_err) begin
                err_cnt <= 8'd0;
            end else if (en && w_bad && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            case (r_state)
                INIT: begin
                    // Phase is still 00 here, so any difference is the first filtered update.
                    if (w_ab != r_phase) begin
                        r_phase <= w_ab;
                        r_state <= TRACK;
                    end else if (w_a_quiet && w_b_quiet) begin
                        if (r_init_cnt == 4'(FILT_LEN - 1)) begin
                            r_state <= TRACK;
                        end else begin
                            r_init_cnt <= r_init_cnt + 4'd1;
                        end
                    end else begin
                        r_init_cnt <= 4'd0;
                    end
                end
                TRACK: begin
                    r_phase <= w_ab;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
//  tb_quad_decoder -- directed and random stimulus against a windowed model
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_quad_decoder;

    localparam int FILT_LEN = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       a_in    = 1'b0;
    logic       b_in    = 1'b0;
    logic       en      = 1'b1;
    logic       clr_err = 1'b0;
    logic       inc;
    logic       dec;
    logic       err;
    logic [7:0] err_cnt;

    quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .en      (en),
        .clr_err (clr_err),
        .inc     (inc),
        .dec     (dec),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: per channel the sampled-input pipeline and the last FILT_LEN synchronized samples.
    bit         m_s1[2];
    bit         m_s2[2];
    bit         m_f[2];
    bit         hist[2][FILT_LEN];
    int         hcnt[2];
    bit         m_init;
    int         m_qcnt;
    logic [1:0] m_phase;
    bit         m_inc, m_dec, m_err;
    int         m_cnt;

    int n_inc, n_dec, n_err, updown, last_drive_cyc;
    bit lat_check = 1'b0;

    function automatic int pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_f[c] = 0; hcnt[c] = 0;
        end
        m_init = 1; m_qcnt = 0; m_phase = 2'b00;
        m_inc = 0; m_dec = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit xa, input bit xb, input bit en_v, input bit clr_v);
        bit         x[2];
        bit         fp[2];
        bit         quiet;
        bit         all_flip;
        logic [1:0] ab;
        int         d;
        x[0] = xa; x[1] = xb;
        quiet = 1;
        for (int c = 0; c < 2; c++) begin
            fp[c] = m_f[c];
            if (!(m_s1[c] == m_s2[c] && m_s2[c] == m_f[c])) quiet = 0;
        end
        ab = {fp[0], fp[1]};
        for (int c = 0; c < 2; c++) begin
            for (int i = FILT_LEN - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = m_s2[c];
            if (hcnt[c] < FILT_LEN) hcnt[c]++;
            // Filtered value flips once the last FILT_LEN synchronized samples all disagree with it.
            all_flip = (hcnt[c] == FILT_LEN);
            for (int i = 0; i < FILT_LEN; i++) if (hist[c][i] == fp[c]) all_flip = 0;
            if (all_flip) m_f[c] = !fp[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = x[c];
        end
        m_inc = 0; m_dec = 0; m_err = 0;
        if (m_init) begin
            if (ab != m_phase) begin
                m_phase = ab; m_init = 0;
            end else if (quiet) begin
                m_qcnt++;
                if (m_qcnt == FILT_LEN) m_init = 0;
            end else begin
                m_qcnt = 0;
            end
        end else begin
            d = (pos(ab) - pos(m_phase) + 4) % 4;
            m_inc = en_v && (d == 1);
            m_dec = en_v && (d == 3);
            m_err = en_v && (d == 2);
            m_phase = ab;
        end
        if (clr_v) m_cnt = 0;
        else if (m_err && m_cnt < 255) m_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge(a_in, b_in, en, clr_err);
        check("inc", int'(inc), int'(m_inc));
        check("dec", int'(dec), int'(m_dec));
        check("err", int'(err), int'(m_err));
        check("err_cnt", int'(err_cnt), m_cnt);
        if (inc) begin
            n_inc++; updown++;
            if (lat_check) check("inc_latency", cyc - last_drive_cyc, 7);
        end
        if (dec) begin n_dec++; updown--; end
        if (err) n_err++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ab(input bit a, input bit b);
        a_in = a; b_in = b; last_drive_cyc = cyc;
    endtask

    task automatic clear_counts();
        n_inc = 0; n_dec = 0; n_err = 0;
    endtask

    int hold_left;

    initial begin
        model_reset();
        updown = 0;
        clear_counts();

        // Reset state, then idle at 00 so INIT latches by stability.
        rst_n = 0;
        hold(3);
        check("reset_err_cnt", int'(err_cnt), 0);
        rst_n = 1;
        set_ab(0, 0);
        hold(10);

        // One forward cycle, each phase held 8 cycles.
        clear_counts();
        lat_check = 1;
        set_ab(0, 1); hold(8);
        set_ab(1, 1); hold(8);
        set_ab(1, 0); hold(8);
        set_ab(0, 0); hold(8);
        lat_check = 0;
        check("fwd_inc_count", n_inc, 4);
        check("fwd_dec_count", n_dec + n_err, 0);
        check("updown_after_fwd", updown, 4);

        // Reverse cycle brings the up/down counter back to zero.
        clear_counts();
        set_ab(1, 0); hold(8);
        set_ab(1, 1); hold(8);
        set_ab(0, 1); hold(8);
        set_ab(0, 0); hold(8);
        check("rev_dec_count", n_dec, 4);
        check("rev_inc_count", n_inc + n_err, 0);
        check("updown_after_rev", updown, 0);

        // A 3-cycle glitch is filtered; a 4-cycle pulse steps out and back.
        clear_counts();
        set_ab(1, 0); hold(3);
        set_ab(0, 0); hold(10);
        check("glitch3_pulses", n_inc + n_dec + n_err, 0);
        set_ab(1, 0); hold(4);
        set_ab(0, 0); hold(12);
        check("pulse4_inc", n_inc, 1);
        check("pulse4_dec", n_dec, 1);

        // Two-bit changes: error pulses and saturation.
        clear_counts();
        set_ab(1, 1); hold(8);
        check("first_err_count", n_err, 1);
        check("first_err_cnt", int'(err_cnt), 1);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) set_ab(0, 0); else set_ab(1, 1);
            hold(7);
        end
        check("err_cnt_saturated", int'(err_cnt), 255);
        clr_err = 1;
        step();
        clr_err = 0;
        check("err_cnt_cleared", int'(err_cnt), 0);

        // Disabled steps stay silent; re-enabling emits nothing until a new step.
        clear_counts();
        en = 0;
        set_ab(1, 0); hold(8);
        set_ab(0, 0); hold(8);
        en = 1;
        hold(8);
        check("masked_pulses", n_inc + n_dec + n_err, 0);
        set_ab(0, 1); hold(8);
        check("reenable_inc", n_inc, 1);
        check("reenable_total", n_inc + n_dec + n_err, 1);

        // Reset released with both channels high.
        rst_n = 0;
        set_ab(1, 1);
        hold(2);
        rst_n = 1;
        clear_counts();
        hold(12);
        check("init11_pulses", n_inc + n_dec + n_err, 0);
        set_ab(1, 0); hold(8);
        check("init11_step_inc", n_inc, 1);
        set_ab(0, 1);
        for (int i = 0; i < 12 && !err; i++) step();
        check("err_before_reset", int'(err), 1);
        rst_n = 0;
        #1;
        check("async_rst_err", int'(err), 0);
        check("async_rst_inc", int'(inc | dec), 0);
        check("async_rst_err_cnt", int'(err_cnt), 0);
        model_reset();
        hold(2);
        rst_n = 1;

        // Randomized phase.
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_left == 0) begin
                set_ab($urandom % 2, $urandom % 2);
                hold_left = $urandom_range(1, 10);
            end
            hold_left--;
            if ($urandom % 20 == 0) en = $urandom % 4 != 0;
            clr_err = ($urandom % 50 == 0);
            rst_n   = ($urandom % 1000 != 0);
            step();
        end
        rst_n = 1;
        clr_err = 0;
        hold(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
